// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: a single-outstanding-request fetch FSM with PC
// redirect (jump/branch), decode stall handling through a one-entry hold
// buffer, and the IF/ID pipeline register.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc_plus4,
  output logic        if_valid
);

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc_plus4_q, if_pc_plus4_d;
  logic        if_valid_q, if_valid_d;

  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pc_plus4;

  // Jump wins over branch; redirect targets are always word aligned.
  always_comb begin
    redirect    = jump | branch_taken;
    redirect_pc = jump ? jump_target : branch_target;
    redirect_pc = {redirect_pc[31:2], 2'b00};
    pc_plus4    = pc_q + 32'd4;
  end

  // Next-state, PC, kill flag, hold buffer and IF/ID register updates.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    kill_d        = kill_q;
    hold_d        = hold_q;
    if_instr_d    = if_instr_q;
    if_pc_plus4_d = if_pc_plus4_q;
    // Without a stall the IF/ID stage drains to a bubble unless something is delivered below.
    if_valid_d    = stall ? if_valid_q : 1'b0;

    unique case (state_q)
      S_RESET: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        // The request goes out regardless; a redirect only marks it for discard.
        state_d = S_WAIT;
        if (redirect) kill_d = 1'b1;
      end
      S_WAIT: begin
        if (imem_valid) begin
          state_d = S_FETCH;
          if (kill_q || redirect) begin
            kill_d = 1'b0;
          end else if (!stall) begin
            if_instr_d    = imem_rdata;
            if_pc_plus4_d = pc_plus4;
            if_valid_d    = 1'b1;
            pc_d          = pc_plus4;
          end else begin
            hold_d  = imem_rdata;
            state_d = S_HOLD;
          end
        end else if (redirect) begin
          kill_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          state_d = S_FETCH;
        end else if (!stall) begin
          if_instr_d    = hold_q;
          if_pc_plus4_d = pc_plus4;
          if_valid_d    = 1'b1;
          pc_d          = pc_plus4;
          state_d       = S_FETCH;
        end
      end
      default: begin
        state_d = S_RESET;
      end
    endcase

    // Redirect flushes IF/ID and overrides both stall and any delivery above.
    if (redirect) begin
      pc_d       = redirect_pc;
      if_valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_RESET;
      pc_q          <= RESET_PC;
      kill_q        <= 1'b0;
      hold_q        <= 32'd0;
      if_instr_q    <= 32'd0;
      if_pc_plus4_q <= 32'd0;
      if_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      kill_q        <= kill_d;
      hold_q        <= hold_d;
      if_instr_q    <= if_instr_d;
      if_pc_plus4_q <= if_pc_plus4_d;
      if_valid_q    <= if_valid_d;
    end
  end

  // Request is a combinational decode of the fetch state, masked during reset.
  always_comb begin
    imem_req    = (state_q == S_FETCH) && !rst;
    imem_addr   = pc_q;
    if_instr    = if_instr_q;
    if_pc_plus4 = if_pc_plus4_q;
    if_valid    = if_valid_q;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        jump;
  logic [31:0] jump_target;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_rdata;
  logic        imem_valid;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] if_instr;
  logic [31:0] if_pc_plus4;
  logic        if_valid;

  logic        imem_req2;
  logic [31:0] imem_addr2;
  logic [31:0] if_instr2;
  logic [31:0] if_pc_plus42;
  logic        if_valid2;

  int checks = 0;
  int errors = 0;

  instr_fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_valid    (imem_valid),
    .if_instr      (if_instr),
    .if_pc_plus4   (if_pc_plus4),
    .if_valid      (if_valid)
  );

  // Second instance exercising PC wrap from the top of the address space.
  instr_fetch_unit #(
    .RESET_PC (32'hFFFF_FFFC)
  ) dut_wrap (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req2),
    .imem_addr     (imem_addr2),
    .imem_rdata    (imem_rdata),
    .imem_valid    (imem_valid),
    .if_instr      (if_instr2),
    .if_pc_plus4   (if_pc_plus42),
    .if_valid      (if_valid2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled at the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Starting in S_FETCH with stall=0: request, one-cycle response, delivery.
  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data);
    check("fetch_req", {31'd0, imem_req}, 32'd1);
    check("fetch_addr", imem_addr, addr);
    step();
    check("wait_noreq", {31'd0, imem_req}, 32'd0);
    imem_valid = 1'b1;
    imem_rdata = data;
    step();
    imem_valid = 1'b0;
    check("deliver_valid", {31'd0, if_valid}, 32'd1);
    check("deliver_instr", if_instr, data);
    check("deliver_pc4", if_pc_plus4, addr + 32'd4);
  endtask

  initial begin
    rst           = 1'b1;
    stall         = 1'b0;
    jump          = 1'b0;
    jump_target   = 32'd0;
    branch_taken  = 1'b0;
    branch_target = 32'd0;
    imem_rdata    = 32'd0;
    imem_valid    = 1'b0;

    // Reset state
    step();
    step();
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, if_valid}, 32'd0);
    check("rst_instr", if_instr, 32'd0);
    check("rst_pc4", if_pc_plus4, 32'd0);

    // Release reset: S_RESET -> S_FETCH
    rst = 1'b0;
    step();
    check("wrap_addr0", imem_addr2, 32'hFFFF_FFFC);
    do_fetch(32'h0, 32'hA000_0000);
    check("wrap_pc4", if_pc_plus42, 32'h0);
    check("wrap_addr1", imem_addr2, 32'h0);
    do_fetch(32'h4, 32'hA000_0001);
    do_fetch(32'h8, 32'hA000_0002);

    // Stall while the response arrives: outputs frozen, buffered in S_HOLD
    stall = 1'b1;
    check("stall_req", {31'd0, imem_req}, 32'd1);
    check("stall_addr", imem_addr, 32'hC);
    step();
    imem_valid = 1'b1;
    imem_rdata = 32'hB000_0000;
    step();
    imem_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("hold_state", 32'(dut.state_q), 32'd3);
      check("hold_valid", {31'd0, if_valid}, 32'd1);
      check("hold_instr", if_instr, 32'hA000_0002);
      check("hold_pc4", if_pc_plus4, 32'hC);
      check("hold_noreq", {31'd0, imem_req}, 32'd0);
      step();
    end
    stall = 1'b0;
    check("hold_state_last", 32'(dut.state_q), 32'd3);
    step();
    check("unhold_valid", {31'd0, if_valid}, 32'd1);
    check("unhold_instr", if_instr, 32'hB000_0000);
    check("unhold_pc4", if_pc_plus4, 32'h10);

    // Jump during S_WAIT, response two cycles later is discarded
    check("jmp_fetch_addr", imem_addr, 32'h10);
    step();
    jump        = 1'b1;
    jump_target = 32'h0000_0040;
    step();
    jump = 1'b0;
    check("jmp_wait_noreq", {31'd0, imem_req}, 32'd0);
    check("jmp_flush", {31'd0, if_valid}, 32'd0);
    step();
    imem_valid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_valid = 1'b0;
    check("jmp_discard_valid", {31'd0, if_valid}, 32'd0);
    do_fetch(32'h40, 32'hC000_0000);

    // Jump and branch in the same S_FETCH cycle: jump wins
    jump          = 1'b1;
    jump_target   = 32'h80;
    branch_taken  = 1'b1;
    branch_target = 32'h20;
    check("prio_req", {31'd0, imem_req}, 32'd1);
    check("prio_old_addr", imem_addr, 32'h44);
    step();
    jump         = 1'b0;
    branch_taken = 1'b0;
    imem_valid   = 1'b1;
    imem_rdata   = 32'hDEAD_0001;
    step();
    imem_valid = 1'b0;
    check("prio_addr", imem_addr, 32'h80);
    check("prio_req2", {31'd0, imem_req}, 32'd1);
    check("prio_flush", {31'd0, if_valid}, 32'd0);

    // Branch with unaligned target, coinciding with the response
    step();
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0013;
    imem_valid    = 1'b1;
    imem_rdata    = 32'hDEAD_0002;
    step();
    branch_taken = 1'b0;
    imem_valid   = 1'b0;
    check("br_align_addr", imem_addr, 32'h10);
    check("br_flush", {31'd0, if_valid}, 32'd0);
    do_fetch(32'h10, 32'hD000_0000);

    // Reset mid-request; a late response is ignored
    step();
    rst = 1'b1;
    step();
    check("mid_rst_req", {31'd0, imem_req}, 32'd0);
    check("mid_rst_valid", {31'd0, if_valid}, 32'd0);
    rst        = 1'b0;
    imem_valid = 1'b1;
    imem_rdata = 32'hDEAD_0003;
    step();
    imem_valid = 1'b0;
    check("late_valid", {31'd0, if_valid}, 32'd0);
    do_fetch(32'h0, 32'hE000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
